cdc_toggle_handshake: RTL and testbench
=======================================

# cdc_toggle_handshake

Parametrised toggle-based clock-domain-crossing channel carrying a DATA_W-bit payload from the s_clk domain to the r_clk domain. It is the successor to the single-bit pulse-to-toggle / toggle-to-pulse pair. It adds:
- a bundled data path;
- a configurable synchroniser depth;
- an optional acknowledge toggle returned to the sender for flow control;
- saturating overflow accounting for pulses that cannot be accepted.

It sits between a sender and a receiver running on unrelated clocks.

## Interface
Parameters:
- DATA_W, 4, payload width in bits (1..64).
- SYNC_STAGES, 2, flops per synchroniser chain in each direction (2..4).
- ACK_MODE, 1: 1 = closed-loop handshake with returned acknowledge; 0 = open-loop, sender must space pulses itself.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- s_clk  input  1  sender clock.
- r_clk  input  1  receiver clock.
- rst  input  1  reset, asynchronous, active-low; resets every flop in both domains.
- s_valid  input  1  sender request pulse (s_clk).
- s_data  input  DATA_W  payload, sampled with s_valid.
- s_ready  output  1  channel idle, s_valid will be accepted (s_clk).
- s_drop  output  1  one-cycle pulse: s_valid arrived while s_ready=0 (s_clk).
- s_drop_cnt  output  DROP_W  saturating count of dropped requests (s_clk).
- r_valid  output  1  one-cycle delivery pulse (r_clk).
- r_data  output  DATA_W  delivered payload, held until next delivery (r_clk).

## Operation
- Source state: s_tog (1 bit), s_hold (DATA_W), s_ack_sync chain, s_busy.
- Accept:
  - s_valid=1 and s_ready=1 at a posedge s_clk -> s_hold<=s_data, s_tog<=~s_tog.
  - ACK_MODE=1: also s_busy<=1.
- s_ready:
  - ACK_MODE=1: s_ready = ~s_busy.
  - ACK_MODE=0: s_ready constant 1.
- Busy clears when the last stage of s_ack_sync equals s_tog: s_busy<=0 on that edge.
- Drop:
  - s_valid=1 and s_ready=0 -> s_drop=1 next cycle.
  - s_drop_cnt increments, saturates at 2^DROP_W-1, never wraps.
  - s_hold and s_tog are unchanged.
- Destination: r_sync chain of SYNC_STAGES flops on s_tog, plus r_prev.
  - Registered edge detect: r_valid <= r_sync[last] ^ r_prev; r_prev <= r_sync[last].
  - On that same condition r_data <= s_hold. s_hold is guaranteed stable because it only changes on accept, and accept requires the prior ack.
- Acknowledge (ACK_MODE=1): r_prev is the ack toggle. It crosses back through the SYNC_STAGES s_clk flops of s_ack_sync.
- ACK_MODE=0:
  - The ack chain and s_busy are removed; s_drop is constant 0 and s_drop_cnt stays 0.
  - Sender contract: consecutive s_valid are spaced at least SYNC_STAGES+2 r_clk periods apart in time. Violation is not detected.
- Source FSM (ACK_MODE=1):
  - IDLE -> (accept) -> WAIT_ACK.
  - WAIT_ACK -> (ack sync == s_tog) -> IDLE.
  - s_valid in WAIT_ACK -> drop, stay in WAIT_ACK.
- Simultaneous ack arrival and s_valid on the same edge: s_ready is still 0 on that edge, so the request is dropped. s_ready rises the following cycle.
- Reset mid-transfer: both domains clear together. The in-flight payload is lost, no r_valid is produced for it, and s_ready=1 after reset.

## Timing
- Reset values:
  - s_ready=1, s_drop=0, s_drop_cnt=0.
  - r_valid=0, r_data=0.
  - all toggles, sync chains and s_hold = 0.
- Forward latency: r_valid is asserted SYNC_STAGES+1 r_clk posedges after the first r_clk posedge that samples the new s_tog. Metastability uncertainty adds +1 r_clk.
- r_valid is high for exactly one r_clk cycle per accepted request.
- r_data changes only on the edge that raises r_valid.
- Return latency: s_ready rises SYNC_STAGES+1 s_clk posedges after the first s_clk edge that samples the new r_prev, with +1 s_clk uncertainty.
- Minimum round trip is s_tog flip to s_ready=1. For SYNC_STAGES=2 this is 3 r_clk + 3 s_clk periods, +1 of each for sampling.
- s_drop pulse: 1 s_clk cycle, the cycle after the offending s_valid.

## Test plan
- Basic transfer:
  - Setup: SYNC_STAGES=2, ACK_MODE=1, s_clk period 20 ns, r_clk period 18 ns. Send s_data=4'hA.
  - Required: exactly one r_valid with r_data=4'hA, within 4 r_clk of the toggle; s_ready low from the cycle after accept until the ack returns, then 1.
- Back-to-back request:
  - Stimulus: s_valid=1 for 3 consecutive s_clk cycles with data 1, 2, 3.
  - Required: data 1 delivered; two s_drop pulses; s_drop_cnt=2; no second r_valid.
- Saturation: DROP_W=2, hold s_valid=1 for 10 cycles while busy -> s_drop_cnt stops at 3.
- Stream:
  - Stimulus: send 0..15, each issued on the first cycle s_ready=1; clocks swapped (r_clk 30 ns, s_clk 10 ns).
  - Required: 16 r_valid pulses, in order, with r_data matching, and zero drops.
- Open loop: ACK_MODE=0, pulses spaced 5 r_clk apart, data 5, 6, 7 -> three r_valid in order; s_ready constant 1.
- Reset mid-flight: assert rst 1 s_clk after accepting 4'hC, hold for 2 cycles -> all outputs at reset values; no r_valid after release; next send 4'h3 is delivered normally.

Source files
------------

// File: rtl/cdc_toggle_handshake.sv
// Toggle-based CDC channel: bundled payload from s_clk to r_clk with an optional
// returned acknowledge toggle for flow control and saturating drop accounting.
module cdc_toggle_handshake #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_MODE    = 1,
    parameter int unsigned DROP_W      = 8
) (
    input  logic              s_clk,
    input  logic              r_clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              s_drop,
    output logic [DROP_W-1:0] s_drop_cnt,
    output logic              r_valid,
    output logic [DATA_W-1:0] r_data
);

    localparam int unsigned LAST = SYNC_STAGES - 1;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } src_state_t;

    src_state_t               state;
    logic                     s_tog;
    logic [DATA_W-1:0]        s_hold;
    logic [SYNC_STAGES-1:0]   s_ack_sync;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_prev;
    logic                     accept;
    logic                     r_edge;

    assign accept = s_valid & s_ready;
    assign r_edge = r_sync[LAST] ^ r_prev;

    // Source domain: payload capture, request toggle, ack return and drop accounting.
    always_ff @(posedge s_clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            s_tog      <= 1'b0;
            s_hold     <= '0;
            s_ack_sync <= '0;
            s_ready    <= 1'b1;
            s_drop     <= 1'b0;
            s_drop_cnt <= '0;
        end else begin
            s_drop <= 1'b0;
            if (accept) begin
                s_hold <= s_data;
                s_tog  <= ~s_tog;
            end
            if (ACK_MODE != 0) begin
                s_ack_sync <= {s_ack_sync[SYNC_STAGES-2:0], r_prev};
                case (state)
                    IDLE: begin
                        if (s_valid) begin
                            state   <= WAIT_ACK;
                            s_ready <= 1'b0;
                        end
                    end
                    WAIT_ACK: begin
                        // s_ready stays low on the ack edge, so a coincident request is dropped
                        if (s_ack_sync[LAST] == s_tog) begin
                            state   <= IDLE;
                            s_ready <= 1'b1;
                        end
                        if (s_valid) begin
                            s_drop <= 1'b1;
                            if (s_drop_cnt != DROP_MAX) begin
                                s_drop_cnt <= s_drop_cnt + DROP_W'(1);
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        s_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Destination domain: toggle synchroniser, registered edge detect, payload capture.
    // r_prev doubles as the acknowledge toggle returned to the source.
    always_ff @(posedge r_clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], s_tog};
            r_prev  <= r_sync[LAST];
            r_valid <= r_edge;
            if (r_edge) begin
                r_data <= s_hold;
            end
        end
    end

endmodule

// File: tb/tb_cdc_toggle_handshake.sv
// Directed bench for cdc_toggle_handshake: closed-loop, saturating and open-loop
// instances share clocks and reset; each scenario task checks its own results.
module tb_cdc_toggle_handshake;

    logic       s_clk = 1'b0;
    logic       r_clk = 1'b0;
    logic       rst   = 1'b0;
    int         s_half = 10;
    int         r_half = 9;

    always #(s_half) s_clk = ~s_clk;
    always #(r_half) r_clk = ~r_clk;

    // main closed-loop instance
    logic       s_valid = 1'b0;
    logic [3:0] s_data  = '0;
    logic       s_ready, s_drop, r_valid;
    logic [7:0] s_drop_cnt;
    logic [3:0] r_data;

    // saturation instance (DROP_W=2)
    logic       sat_valid = 1'b0;
    logic [3:0] sat_data  = '0;
    logic       sat_ready, sat_drop, sat_rvalid;
    logic [1:0] sat_cnt;
    logic [3:0] sat_rdata;

    // open-loop instance
    logic       ol_valid = 1'b0;
    logic [3:0] ol_data  = '0;
    logic       ol_ready, ol_drop, ol_rvalid;
    logic [7:0] ol_cnt;
    logic [3:0] ol_rdata;

    cdc_toggle_handshake #(.DATA_W(4), .SYNC_STAGES(2), .ACK_MODE(1), .DROP_W(8)) u_dut (
        .s_clk(s_clk), .r_clk(r_clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .s_drop(s_drop),
        .s_drop_cnt(s_drop_cnt), .r_valid(r_valid), .r_data(r_data)
    );

    cdc_toggle_handshake #(.DATA_W(4), .SYNC_STAGES(2), .ACK_MODE(1), .DROP_W(2)) u_sat (
        .s_clk(s_clk), .r_clk(r_clk), .rst(rst),
        .s_valid(sat_valid), .s_data(sat_data), .s_ready(sat_ready), .s_drop(sat_drop),
        .s_drop_cnt(sat_cnt), .r_valid(sat_rvalid), .r_data(sat_rdata)
    );

    cdc_toggle_handshake #(.DATA_W(4), .SYNC_STAGES(2), .ACK_MODE(0), .DROP_W(8)) u_ol (
        .s_clk(s_clk), .r_clk(r_clk), .rst(rst),
        .s_valid(ol_valid), .s_data(ol_data), .s_ready(ol_ready), .s_drop(ol_drop),
        .s_drop_cnt(ol_cnt), .r_valid(ol_rvalid), .r_data(ol_rdata)
    );

    int errors = 0;
    int checks = 0;

    // delivery and drop monitors, sampled away from the active edges
    logic [3:0] rv_q[$];
    logic [3:0] ol_q[$];
    realtime    rv_time;
    realtime    acc_time;
    int         drop_pulses = 0;
    int         sat_pulses  = 0;
    int         ol_ready_low = 0;

    always @(negedge r_clk) begin
        if (r_valid) begin
            rv_q.push_back(r_data);
            rv_time = $realtime;
        end
        if (ol_rvalid) ol_q.push_back(ol_rdata);
    end

    always @(negedge s_clk) begin
        if (s_drop)    drop_pulses++;
        if (sat_drop)  sat_pulses++;
        if (!ol_ready) ol_ready_low++;
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge s_clk);
            #1;
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input logic [3:0] d, output bit ok);
        wait_ready(ok);
        if (!ok) return;
        s_valid = 1'b1;
        s_data  = d;
        @(posedge s_clk);
        acc_time = $realtime;
        #1;
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge s_clk);
        #1;
        checks++; if (s_ready !== 1'b1)    begin errors++; $display("FAIL reset_ready got=%b exp=1", s_ready); end
        checks++; if (s_drop !== 1'b0)     begin errors++; $display("FAIL reset_drop got=%b exp=0", s_drop); end
        checks++; if (s_drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", s_drop_cnt); end
        checks++; if (r_valid !== 1'b0)    begin errors++; $display("FAIL reset_rvalid got=%b exp=0", r_valid); end
        checks++; if (r_data !== 4'h0)     begin errors++; $display("FAIL reset_rdata got=%h exp=0", r_data); end
        rst = 1'b1;
        repeat (4) @(posedge s_clk);
        #1;
        checks++; if (s_ready !== 1'b1 || r_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle ready=%b rvalid=%b exp ready=1 rvalid=0", s_ready, r_valid);
        end
    endtask

    task automatic test_basic();
        bit ok;
        rv_q.delete();
        send(4'hA, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_send_timeout ready never 1"); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", s_ready); end
        wait_ready(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_ack_timeout ready never returned"); end
        repeat (4) @(posedge r_clk);
        #1;
        checks++; if (rv_q.size() != 1) begin errors++; $display("FAIL basic_count got=%0d exp=1", rv_q.size()); end
        checks++; if (rv_q.size() == 0 || rv_q[0] !== 4'hA) begin
            errors++; $display("FAIL basic_data got=%h exp=a", (rv_q.size() == 0) ? 4'hx : rv_q[0]);
        end
        checks++; if (rv_q.size() == 0 || (rv_time - acc_time) > realtime'(9 * r_half)) begin
            errors++; $display("FAIL basic_latency got=%0t exp<=%0d", rv_time - acc_time, 9 * r_half);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int drops0;
        rv_q.delete();
        drops0 = drop_pulses;
        wait_ready(ok);
        s_valid = 1'b1; s_data = 4'h1;
        @(posedge s_clk); #1; s_data = 4'h2;
        @(posedge s_clk); #1; s_data = 4'h3;
        @(posedge s_clk); #1; s_valid = 1'b0;
        wait_ready(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_ack_timeout ready never returned"); end
        repeat (6) @(posedge r_clk);
        #1;
        checks++; if (rv_q.size() != 1 || rv_q[0] !== 4'h1) begin
            errors++; $display("FAIL b2b_delivery count=%0d exp count=1 data=1", rv_q.size());
        end
        checks++; if (drop_pulses - drops0 != 2) begin
            errors++; $display("FAIL b2b_drop_pulses got=%0d exp=2", drop_pulses - drops0);
        end
        checks++; if (s_drop_cnt !== 8'd2) begin errors++; $display("FAIL b2b_drop_cnt got=%0d exp=2", s_drop_cnt); end
    endtask

    task automatic test_saturation();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge s_clk); #1;
            if (sat_ready) begin ok = 1'b1; break; end
        end
        sat_valid = 1'b1; sat_data = 4'h9;
        repeat (11) @(posedge s_clk);
        #1;
        sat_valid = 1'b0;
        checks++; if (sat_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt got=%0d exp=3", sat_cnt); end
        checks++; if (sat_pulses < 4) begin errors++; $display("FAIL sat_pulses got=%0d exp>=4", sat_pulses); end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge s_clk); #1;
            if (sat_ready) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || sat_cnt !== 2'd3) begin
            errors++; $display("FAIL sat_hold ready=%b cnt=%0d exp ready=1 cnt=3", ok, sat_cnt);
        end
    endtask

    task automatic test_stream();
        bit ok;
        int drops0;
        s_half = 5;
        r_half = 15;
        repeat (4) @(posedge r_clk);
        rv_q.delete();
        drops0 = drop_pulses;
        for (int i = 0; i < 16; i++) begin
            send(4'(i), ok);
            if (!ok) break;
        end
        checks++; if (!ok) begin errors++; $display("FAIL stream_send_timeout ready never 1"); end
        wait_ready(ok);
        repeat (4) @(posedge r_clk);
        #1;
        checks++; if (rv_q.size() != 16) begin errors++; $display("FAIL stream_count got=%0d exp=16", rv_q.size()); end
        for (int i = 0; i < rv_q.size() && i < 16; i++) begin
            checks++; if (rv_q[i] !== 4'(i)) begin
                errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, rv_q[i], 4'(i));
            end
        end
        checks++; if (drop_pulses != drops0 || s_drop_cnt !== 8'd2) begin
            errors++; $display("FAIL stream_drops pulses=%0d cnt=%0d exp pulses=0 cnt=2", drop_pulses - drops0, s_drop_cnt);
        end
        s_half = 10;
        r_half = 9;
        repeat (4) @(posedge s_clk);
    endtask

    task automatic test_open_loop();
        logic [3:0] vals [3];
        vals[0] = 4'h5; vals[1] = 4'h6; vals[2] = 4'h7;
        ol_q.delete();
        ol_ready_low = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge s_clk); #1;
            ol_valid = 1'b1; ol_data = vals[i];
            @(posedge s_clk); #1;
            ol_valid = 1'b0;
            repeat (5) @(posedge r_clk);
        end
        repeat (6) @(posedge r_clk);
        #1;
        checks++; if (ol_q.size() != 3) begin errors++; $display("FAIL ol_count got=%0d exp=3", ol_q.size()); end
        for (int i = 0; i < ol_q.size() && i < 3; i++) begin
            checks++; if (ol_q[i] !== vals[i]) begin
                errors++; $display("FAIL ol_data[%0d] got=%h exp=%h", i, ol_q[i], vals[i]);
            end
        end
        checks++; if (ol_ready_low != 0 || ol_drop !== 1'b0 || ol_cnt !== 8'd0) begin
            errors++; $display("FAIL ol_ready_drop low_cycles=%0d drop=%b cnt=%0d exp 0 0 0", ol_ready_low, ol_drop, ol_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        send(4'hC, ok);
        @(posedge s_clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge s_clk);
        #1;
        checks++; if (s_ready !== 1'b1 || s_drop !== 1'b0 || s_drop_cnt !== 8'd0) begin
            errors++; $display("FAIL rstmid_src ready=%b drop=%b cnt=%0d exp 1 0 0", s_ready, s_drop, s_drop_cnt);
        end
        checks++; if (r_valid !== 1'b0 || r_data !== 4'h0) begin
            errors++; $display("FAIL rstmid_dst rvalid=%b rdata=%h exp 0 0", r_valid, r_data);
        end
        rv_q.delete();
        rst = 1'b1;
        repeat (20) @(posedge s_clk);
        #1;
        checks++; if (rv_q.size() != 0) begin errors++; $display("FAIL rstmid_ghost got=%0d exp=0", rv_q.size()); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", s_ready); end
        send(4'h3, ok);
        wait_ready(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_ack_timeout ready never returned"); end
        repeat (4) @(posedge r_clk);
        #1;
        checks++; if (rv_q.size() != 1 || rv_q[0] !== 4'h3 || r_data !== 4'h3) begin
            errors++; $display("FAIL rstmid_resend count=%0d rdata=%h exp count=1 data=3", rv_q.size(), r_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturation();
        test_stream();
        test_open_loop();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
